// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI bus master: transfer size codes, control-word
// field positions and the FSM state encoding.
// No ports (package only).
package spi_bus_pkg;

  // Transfer size codes. Only SIZE_16 selects a 16-bit data phase; every
  // other code, including SIZE_8, moves 32 bits.
  localparam logic [1:0] SIZE_8  = 2'b00;
  localparam logic [1:0] SIZE_16 = 2'b01;
  localparam logic [1:0] SIZE_32 = 2'b11;

  // Control-word layout, sent MSB first: {write, size[1:0], addr[12:0]}.
  localparam int CW_WRITE   = 15;
  localparam int CW_SIZE_HI = 14;
  localparam int CW_SIZE_LO = 13;
  localparam int CW_ADDR_HI = 12;
  localparam int CW_ADDR_LO = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CTRL = 3'd1,
    TURN = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } state_t;

  function automatic logic [15:0] ctrl_word(input logic wr, input logic [1:0] size,
                                            input logic [12:0] addr);
    logic [15:0] cw;
    cw = '0;
    cw[CW_WRITE]                = wr;
    cw[CW_SIZE_HI:CW_SIZE_LO]   = size;
    cw[CW_ADDR_HI:CW_ADDR_LO]   = addr;
    return cw;
  endfunction

endpackage

// File: rtl/spi_bus_master_shift.sv
// Purpose: 32-bit MSB-first shift register with parallel load, serial out, serial in.
// Latency: load/shift take effect on the next spiClk edge; no backpressure (caller gates shift_en).
// Ports: load/load_dat parallel load (wins over shift), shift_en/serial_in shift left,
//        serial_out = current MSB, par_dat = low 31 bits of the register.
module spi_shift_reg (
  input  logic        spiClk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_dat,
  input  logic        shift_en,
  input  logic        serial_in,
  output logic        serial_out,
  output logic [30:0] par_dat
);

  logic [31:0] sr_q;
  logic [31:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_dat;
    end else if (shift_en) begin
      sr_d = {sr_q[30:0], serial_in};
    end
  end

  always_ff @(posedge spiClk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial_out = sr_q[31];
  assign par_dat    = sr_q[30:0];

endmodule

// File: rtl/spi_bus_master.sv
// Purpose: SPI bus master issuing 16-bit control word then 16/32-bit write or read data.
// Latency: write holds spiCS 16+N cycles, read 16+RD_LATENCY+N; done pulses the cycle after the last bit.
// Backpressure: req is only taken in IDLE; requests while busy are dropped, not queued.
// Ports: req/reqWrite/reqSize/reqAddr/reqData request; busy/done/rdData status;
//        spiCS/spiMosi/spiMiso serial bus; abort only when SPI_MASTER_ABORT_EN is defined.
// RD_LATENCY legal 0..7, IDLE_GAP legal 1..7.
module spi_bus_master
  import spi_bus_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int IDLE_GAP   = 2
) (
  input  logic        reset,
  input  logic        spiClk,
  input  logic        req,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic [12:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdData,
  output logic        spiCS,
  output logic        spiMosi,
  input  logic        spiMiso
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam logic [5:0] RL_M1  = (RD_LATENCY > 0) ? 6'(RD_LATENCY - 1) : 6'd0;
  localparam logic [5:0] GAP_M1 = 6'(IDLE_GAP - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;        // shared down-counter: ctrl bits, turn, data bits, gap
  logic [14:0] ctrl_q, ctrl_d;      // control bits still to be sent
  logic        wr_q, wr_d;
  logic        sz16_q, sz16_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;

  logic        abort_now;
  logic [15:0] cw;
  logic [5:0]  n_m1;
  logic        sr_load;
  logic        sr_shift;
  logic [31:0] sr_load_dat;
  logic        sr_out;
  logic [30:0] sr_par;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  assign cw   = ctrl_word(reqWrite, reqSize, reqAddr);
  assign n_m1 = sz16_q ? 6'd15 : 6'd31;
  // 16-bit payload is left-aligned so the MSB of the payload leaves first.
  assign sr_load_dat = (reqSize == SIZE_16) ? {reqData[15:0], 16'h0} : reqData;

  spi_shift_reg u_shift (
    .spiClk     (spiClk),
    .reset      (reset),
    .load       (sr_load),
    .load_dat   (sr_load_dat),
    .shift_en   (sr_shift),
    .serial_in  (spiMiso),
    .serial_out (sr_out),
    .par_dat    (sr_par)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    wr_d      = wr_q;
    sz16_d    = sz16_q;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;
    cs_d      = cs_q;
    mosi_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = reqWrite;
          sz16_d  = (reqSize == SIZE_16);
          ctrl_d  = cw[14:0];
          mosi_d  = cw[15];
          cs_d    = 1'b1;
          cnt_d   = 6'd15;
          sr_load = 1'b1;
          state_d = CTRL;
        end
      end
      CTRL: begin
        if (abort_now) begin
          state_d = GAP;
          cs_d    = 1'b0;
          cnt_d   = GAP_M1;
        end else if (cnt_q != 6'd0) begin
          mosi_d = ctrl_q[14];
          ctrl_d = {ctrl_q[13:0], 1'b0};
          cnt_d  = cnt_q - 6'd1;
        end else if (wr_q) begin
          // Writes go straight into data; first payload bit leaves now.
          state_d  = DATA;
          cnt_d    = n_m1;
          mosi_d   = sr_out;
          sr_shift = 1'b1;
        end else if (RD_LATENCY == 0) begin
          state_d = DATA;
          cnt_d   = n_m1;
        end else begin
          state_d = TURN;
          cnt_d   = RL_M1;
        end
      end
      TURN: begin
        if (abort_now) begin
          state_d = GAP;
          cs_d    = 1'b0;
          cnt_d   = GAP_M1;
        end else if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = DATA;
          cnt_d   = n_m1;
        end
      end
      DATA: begin
        // Writes shift payload out, reads shift spiMiso in; one edge per bit.
        sr_shift = 1'b1;
        if (abort_now) begin
          state_d = GAP;
          cs_d    = 1'b0;
          cnt_d   = GAP_M1;
        end else if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
          if (wr_q) begin
            mosi_d = sr_out;
          end
        end else begin
          state_d = GAP;
          cs_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = GAP_M1;
          // Last bit is still on spiMiso, so it is merged in directly.
          if (!wr_q) begin
            rd_data_d = sz16_q ? {16'h0, sr_par[14:0], spiMiso} : {sr_par, spiMiso};
          end
        end
      end
      GAP: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        cnt_d   = 6'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge spiClk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      wr_q      <= 1'b0;
      sz16_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      cs_q      <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      wr_q      <= wr_d;
      sz16_q    <= sz16_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdData  = rd_data_q;
  assign spiCS   = cs_q;
  assign spiMosi = mosi_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Self-checking bench for spi_bus_master: table of transactions plus hand-written
// sequences for ignored requests, gap timing, mid-transfer reset and (when
// SPI_MASTER_ABORT_EN is defined) abort.
module tb_spi_bus_master;

  localparam int RL  = 2;
  localparam int GAP = 2;

  logic        reset = 1'b1;
  logic        spiClk = 1'b0;
  logic        req = 1'b0;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic [12:0] reqAddr = '0;
  logic [31:0] reqData = '0;
  logic        busy, done, spiCS, spiMosi;
  logic [31:0] rdData;
  logic        spiMiso = 1'b0;
  logic        abort_in = 1'b0;

  spi_bus_master #(.RD_LATENCY(RL), .IDLE_GAP(GAP)) dut (
    .reset    (reset),
    .spiClk   (spiClk),
    .req      (req),
    .reqWrite (reqWrite),
    .reqSize  (reqSize),
    .reqAddr  (reqAddr),
    .reqData  (reqData),
    .busy     (busy),
    .done     (done),
    .rdData   (rdData),
    .spiCS    (spiCS),
    .spiMosi  (spiMosi),
    .spiMiso  (spiMiso)
`ifdef SPI_MASTER_ABORT_EN
    ,
    .abort    (abort_in)
`endif
  );

  always #5 spiClk = ~spiClk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;     // word returned by the slave model on reads
    logic [15:0] exp_ctrl;
    int          exp_cs;    // cycles spiCS is high
    logic [31:0] exp_rd;    // read result (reads only)
  } vec_t;

  typedef struct {
    int          cs_len;
    logic [15:0] ctrl;
    logic [63:0] low;       // mosi bits after the control word
    logic [31:0] rd;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] model_rd = '0;

  // slave model state
  logic [31:0] slave_word = '0;
  int          slave_n = 32;
  bit          slave_rd = 1'b0;

  // monitor state
  int          cs_cnt = 0;
  logic [63:0] mosi_bits = '0;
  logic        prev_done = 1'b0;
  int          mon_len;
  logic [15:0] mon_ctrl;
  logic [63:0] mon_low;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + slave: runs on the falling edge, away from the DUT's active edge.
  always @(negedge spiClk) begin
    if (done) begin
      chk("done_width", {63'h0, prev_done}, 64'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        mon_e    = sb.pop_front();
        mon_len  = cs_cnt;
        mon_ctrl = (mon_len >= 16) ? mosi_bits[mon_len-1 -: 16] : 16'h0;
        mon_low  = (mon_len >= 16) ? (mosi_bits & ((64'd1 << (mon_len - 16)) - 64'd1)) : mosi_bits;
        chk("cs_len", 64'(mon_len), 64'(mon_e.cs_len));
        chk("ctrl_word", {48'h0, mon_ctrl}, {48'h0, mon_e.ctrl});
        chk("mosi_data", mon_low, mon_e.low);
        chk("rdData", {32'h0, rdData}, {32'h0, mon_e.rd});
      end
    end
    prev_done = done;
    if (!spiCS) begin
      cs_cnt    = 0;
      mosi_bits = '0;
      spiMiso   = 1'b0;
    end else begin
      if (slave_rd && cs_cnt >= 16 + RL && cs_cnt < 16 + RL + slave_n)
        spiMiso = slave_word[slave_n - 1 - (cs_cnt - 16 - RL)];
      else
        spiMiso = 1'b0;
      mosi_bits = {mosi_bits[62:0], spiMosi};
      cs_cnt++;
    end
  end

  task automatic drive_fields(input vec_t v);
    reqWrite   = v.wr;
    reqSize    = v.size;
    reqAddr    = v.addr;
    reqData    = v.wdata;
    slave_word = v.sdata;
    slave_n    = (v.size == 2'b01) ? 16 : 32;
    slave_rd   = !v.wr;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.cs_len = v.exp_cs;
    e.ctrl   = v.exp_ctrl;
    if (v.wr) begin
      e.low = (v.size == 2'b01) ? {48'h0, v.wdata[15:0]} : {32'h0, v.wdata};
      e.rd  = model_rd;
    end else begin
      e.low    = '0;
      e.rd     = v.exp_rd;
      model_rd = v.exp_rd;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic issue(input vec_t v);
    drive_fields(v);
    push_exp(v);
    req = 1'b1;
    @(negedge spiClk);
    req = 1'b0;
    chk("accept", {63'h0, busy}, 64'h1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge spiClk);
      n++;
    end
    chk(name, {63'h0, done}, 64'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge spiClk);
      n++;
    end
    chk("idle", {63'h0, busy}, 64'h0);
  endtask

  vec_t vecs[7];
  vec_t r32, w16, w32, r16;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    w16 = '{1'b1, 2'b01, 13'h0120, 32'h0000_0123, 32'h0,          16'hA120, 32, 32'h0};
    w32 = '{1'b1, 2'b11, 13'h0124, 32'h7654_3210, 32'h0,          16'hE124, 48, 32'h0};
    r16 = '{1'b0, 2'b01, 13'h0122, 32'h0,          32'h0000_4567, 16'h2122, 34, 32'h0000_4567};
    r32 = '{1'b0, 2'b11, 13'h0124, 32'h0,          32'h7654_3210, 16'h6124, 50, 32'h7654_3210};
    vecs[0] = w16;
    vecs[1] = w32;
    vecs[2] = r16;
    vecs[3] = '{1'b1, 2'b00, 13'h1FFF, 32'hA5A5_0F0F, 32'h0,          16'h9FFF, 48, 32'h0};
    vecs[4] = '{1'b0, 2'b10, 13'h0000, 32'h0,          32'h8000_0001, 16'h4000, 50, 32'h8000_0001};
    vecs[5] = '{1'b1, 2'b01, 13'h0AAA, 32'hDEAD_BEEF, 32'h0,          16'hAAAA, 32, 32'h0};
    vecs[6] = '{1'b0, 2'b01, 13'h1555, 32'h0,          32'h0000_FFFF, 16'h3555, 34, 32'h0000_FFFF};

    // reset state
    repeat (2) @(negedge spiClk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_cs", {63'h0, spiCS}, 64'h0);
    chk("rst_mosi", {63'h0, spiMosi}, 64'h0);
    chk("rst_rdData", {32'h0, rdData}, 64'h0);
    reset = 1'b0;

    // table: first entry is issued right after reset release
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i]);
      wait_done("done_vec");
      wait_idle();
    end

    // Read32 with a request pulsed while busy, then gap timing
    issue(r32);
    repeat (5) @(negedge spiClk);
    req = 1'b1; reqWrite = 1'b1; reqAddr = 13'h1ABC;
    repeat (3) @(negedge spiClk);
    req = 1'b0;
    wait_done("done_r32");
    @(negedge spiClk);                       // second gap cycle
    chk("gap_busy", {63'h0, busy}, 64'h1);
    drive_fields(w16);
    req = 1'b1;
    @(negedge spiClk);                       // first idle cycle: last-gap req not taken
    chk("gap_exit_ignored", {63'h0, busy}, 64'h0);
    chk("gap_exit_cs", {63'h0, spiCS}, 64'h0);
    push_exp(w16);
    @(negedge spiClk);
    req = 1'b0;
    chk("accept_after_gap", {63'h0, busy}, 64'h1);
    wait_done("done_after_gap");
    wait_idle();

    // reset at bit 20 of a Write32
    drive_fields(w32);
    req = 1'b1;
    @(negedge spiClk);
    req = 1'b0;
    repeat (20) @(negedge spiClk);
    #2 reset = 1'b1;
    #1;
    chk("rst_cs_async", {63'h0, spiCS}, 64'h0);
    chk("rst_busy_async", {63'h0, busy}, 64'h0);
    @(negedge spiClk);
    chk("rst_no_done", {63'h0, done}, 64'h0);
    chk("rst_rd_clear", {32'h0, rdData}, 64'h0);
    repeat (2) @(negedge spiClk);
    reset = 1'b0;
    model_rd = '0;
    issue(r16);
    wait_done("done_after_reset");
    wait_idle();

`ifdef SPI_MASTER_ABORT_EN
    // abort at bit 10 of a Read32
    drive_fields(r32);
    req = 1'b1;
    @(negedge spiClk);
    req = 1'b0;
    repeat (10) @(negedge spiClk);
    abort_in = 1'b1;
    @(negedge spiClk);
    abort_in = 1'b0;
    chk("abort_cs", {63'h0, spiCS}, 64'h0);
    chk("abort_no_done", {63'h0, done}, 64'h0);
    chk("abort_rd_hold", {32'h0, rdData}, {32'h0, model_rd});
    chk("abort_gap_busy", {63'h0, busy}, 64'h1);
    wait_idle();
`endif

    repeat (5) @(negedge spiClk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
